// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control blocks: memory address
// sources, memory-sequencer states and access kinds.
package mips_ctrl_pkg;

    localparam logic [1:0] SRC_PC       = 2'b00;
    localparam logic [1:0] SRC_LOADSIZE = 2'b01;
    localparam logic [1:0] SRC_A        = 2'b10;
    localparam logic [1:0] SRC_B        = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } access_kind_t;

endpackage

// File: rtl/mem_access_seq.sv
// Memory access sequencer: arbitrates fetch vs. data requests, holds the
// address source for MEM_WAIT cycles, then pulses done and the IR/MDR loads.
//
// state  | meaning
// IDLE   | address mux parked on PC, waiting for a request (data has priority)
// ACCESS | address held for MEM_WAIT cycles, write strobe driven for stores
// DONE   | one-cycle completion pulse plus IR or MDR load
module mem_access_seq
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch_req,
    input  logic       data_req,
    input  logic [1:0] data_src,
    input  logic       data_wr,
    output logic [1:0] mem_sel,
    output logic       mem_wr,
    output logic       ir_load,
    output logic       mdr_load,
    output logic       fetch_done,
    output logic       data_done,
    output logic       busy
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_WAIT - 1);

    mem_state_t       state;
    access_kind_t     kind_q;
    logic [1:0]       sel_q;
    logic             wr_q;
    logic [CNT_W-1:0] cnt;

    // The address source only leaves PC while an access is in flight.
    assign mem_sel = (state == IDLE) ? SRC_PC : sel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            kind_q     <= FETCH;
            sel_q      <= SRC_PC;
            wr_q       <= 1'b0;
            cnt        <= '0;
            mem_wr     <= 1'b0;
            ir_load    <= 1'b0;
            mdr_load   <= 1'b0;
            fetch_done <= 1'b0;
            data_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ir_load    <= 1'b0;
            mdr_load   <= 1'b0;
            fetch_done <= 1'b0;
            data_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_req) begin
                        state  <= ACCESS;
                        kind_q <= DATA;
                        sel_q  <= data_src;
                        wr_q   <= data_wr;
                        mem_wr <= data_wr;
                        cnt    <= WAIT_LOAD;
                        busy   <= 1'b1;
                    end else if (fetch_req) begin
                        state  <= ACCESS;
                        kind_q <= FETCH;
                        sel_q  <= SRC_PC;
                        wr_q   <= 1'b0;
                        mem_wr <= 1'b0;
                        cnt    <= WAIT_LOAD;
                        busy   <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state  <= DONE;
                        mem_wr <= 1'b0;
                        if (kind_q == FETCH) begin
                            fetch_done <= 1'b1;
                            ir_load    <= 1'b1;
                        end else begin
                            data_done <= 1'b1;
                            mdr_load  <= ~wr_q;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    mem_wr <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: one instance at MEM_WAIT=2 and one at
// MEM_WAIT=1, outputs compared as {mem_sel, wr, ir, mdr, fetch_done, data_done, busy}.
module tb_mem_access_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       fetch_req = 1'b0, data_req = 1'b0, data_wr = 1'b0;
    logic [1:0] data_src = 2'b00;
    logic [1:0] mem_sel;
    logic       mem_wr, ir_load, mdr_load, fetch_done, data_done, busy;

    logic       fetch_req2 = 1'b0, data_req2 = 1'b0, data_wr2 = 1'b0;
    logic [1:0] data_src2 = 2'b00;
    logic [1:0] mem_sel2;
    logic       mem_wr2, ir_load2, mdr_load2, fetch_done2, data_done2, busy2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_seq #(.MEM_WAIT(2), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .data_req(data_req), .data_src(data_src), .data_wr(data_wr),
        .mem_sel(mem_sel), .mem_wr(mem_wr), .ir_load(ir_load), .mdr_load(mdr_load),
        .fetch_done(fetch_done), .data_done(data_done), .busy(busy)
    );

    mem_access_seq #(.MEM_WAIT(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req2), .data_req(data_req2), .data_src(data_src2), .data_wr(data_wr2),
        .mem_sel(mem_sel2), .mem_wr(mem_wr2), .ir_load(ir_load2), .mdr_load(mdr_load2),
        .fetch_done(fetch_done2), .data_done(data_done2), .busy(busy2)
    );

    // flags order: mem_wr, ir_load, mdr_load, fetch_done, data_done, busy
    function automatic logic [7:0] ev(input logic [1:0] sel, input logic [5:0] flags);
        return {sel, flags};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {mem_sel, mem_wr, ir_load, mdr_load, fetch_done, data_done, busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {mem_sel2, mem_wr2, ir_load2, mdr_load2, fetch_done2, data_done2, busy2};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        // 1. reset held two cycles with both requests high
        reset = 1'b1; fetch_req = 1'b1; data_req = 1'b1; data_src = 2'b11; data_wr = 1'b1;
        tick(); chk("rst_c1", ev(2'b00, 6'b000000));
        tick(); chk("rst_c2", ev(2'b00, 6'b000000));
        reset = 1'b0; fetch_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;
        chk("rst_release", ev(2'b00, 6'b000000));
        chk2("rst_release_w1", ev(2'b00, 6'b000000));
        tick(); chk("rst_idle", ev(2'b00, 6'b000000));

        // 2. fetch
        fetch_req = 1'b1;
        tick(); fetch_req = 1'b0;
        chk("fetch_c1", ev(2'b00, 6'b000001));
        tick(); chk("fetch_c2", ev(2'b00, 6'b000001));
        tick(); chk("fetch_c3_done", ev(2'b00, 6'b010101));
        tick(); chk("fetch_c4_idle", ev(2'b00, 6'b000000));

        // 3. store from reg B; source/write changes during ACCESS are ignored
        data_req = 1'b1; data_src = 2'b11; data_wr = 1'b1;
        tick(); data_req = 1'b0; data_src = 2'b00; data_wr = 1'b0;
        chk("store_c1", ev(2'b11, 6'b100001));
        tick(); chk("store_c2", ev(2'b11, 6'b100001));
        tick(); chk("store_c3_done", ev(2'b11, 6'b000011));
        tick(); chk("store_c4_idle", ev(2'b00, 6'b000000));

        // 4. simultaneous requests: LoadSize load first, then the fetch
        fetch_req = 1'b1; data_req = 1'b1; data_src = 2'b01; data_wr = 1'b0;
        tick(); data_req = 1'b0;
        chk("arb_c1", ev(2'b01, 6'b000001));
        tick(); chk("arb_c2", ev(2'b01, 6'b000001));
        tick(); chk("arb_c3_load_done", ev(2'b01, 6'b001011));
        tick(); chk("arb_c4_idle", ev(2'b00, 6'b000000));
        tick(); fetch_req = 1'b0;
        chk("arb_c5_fetch", ev(2'b00, 6'b000001));
        tick(); chk("arb_c6_fetch", ev(2'b00, 6'b000001));
        tick(); chk("arb_c7_fetch_done", ev(2'b00, 6'b010101));
        tick(); chk("arb_c8_idle", ev(2'b00, 6'b000000));

        // 5. reset during a store from reg A
        data_req = 1'b1; data_src = 2'b10; data_wr = 1'b1;
        tick(); data_req = 1'b0; data_wr = 1'b0;
        chk("abort_c1", ev(2'b10, 6'b100001));
        tick(); chk("abort_c2", ev(2'b10, 6'b100001));
        reset = 1'b1;
        tick(); reset = 1'b0;
        chk("abort_c3", ev(2'b00, 6'b000000));
        tick(); chk("abort_c4", ev(2'b00, 6'b000000));
        tick(); chk("abort_c5", ev(2'b00, 6'b000000));

        // 6. MEM_WAIT=1, fetch held: done every 3 cycles, data_src toggles ignored
        fetch_req2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); data_src2 = ~data_src2;
            chk2($sformatf("held_access_%0d", i), ev(2'b00, 6'b000001));
            tick(); data_src2 = ~data_src2;
            chk2($sformatf("held_done_%0d", i), ev(2'b00, 6'b010101));
            if (i == 2) fetch_req2 = 1'b0;
            tick(); data_src2 = ~data_src2;
            chk2($sformatf("held_idle_%0d", i), ev(2'b00, 6'b000000));
        end
        tick(); chk2("held_released", ev(2'b00, 6'b000000));
        chk("w2_untouched", ev(2'b00, 6'b000000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Sequences every memory access of the multicycle MIPS datapath.
- Drives the 2-bit selector of the memory-address mux (00 PC, 01 LoadSize, 10 reg A, 11 reg B) and the memory write strobe.
- Arbitrates between the instruction-fetch requester and the data (load/store) requester.
- Holds the address source stable for the fixed memory latency, then pulses completion and the IR/MDR load enables.

Parameters:
- MEM_WAIT, 2, cycles the address must be held before read data is valid or a write is committed; legal range 1..15.
- CNT_W, 4, width of the wait counter; must hold MEM_WAIT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_req  input  1  level request for an instruction fetch from the PC address; held until fetch_done.
- data_req  input  1  level request for a data access; held until data_done.
- data_src  input  2  address-mux code for the data access; 00/01/10/11 all legal.
- data_wr  input  1  1 = store, 0 = load; qualified by data_req.
- mem_sel  output  2  memory-address mux selector.
- mem_wr  output  1  memory write enable.
- ir_load  output  1  instruction-register load strobe.
- mdr_load  output  1  memory-data-register load strobe.
- fetch_done  output  1  one-cycle completion pulse for a fetch.
- data_done  output  1  one-cycle completion pulse for a data access.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (sync, active-high), taking effect at the next rising clk edge:
  - state goes to IDLE and the counter clears;
  - mem_sel = 00 and all other outputs = 0;
  - reset mid-access aborts the access and drops mem_wr at that edge; no done pulse is issued.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - mem_sel = 00 (PC); all strobes 0.
  - Sampled at edge k:
    - data_req = 1: latch data_src into sel_q and data_wr into wr_q, mark kind = DATA, go to ACCESS.
    - else fetch_req = 1: sel_q = 00, wr_q = 0, kind = FETCH, go to ACCESS.
  - Simultaneous fetch_req and data_req: data wins. fetch_req stays pending and is served in the next IDLE.
- ACCESS:
  - Entered at edge k and lasts exactly MEM_WAIT cycles, k+1 .. k+MEM_WAIT.
  - mem_sel = sel_q.
  - mem_wr = wr_q for every ACCESS cycle.
  - Counter loads MEM_WAIT-1 on entry and decrements; at 0, go to DONE.
  - Request inputs and data_src/data_wr changes are ignored.
- DONE:
  - Lasts one cycle (k+MEM_WAIT+1). mem_sel still = sel_q; mem_wr = 0.
  - Strobes by access kind:
    - FETCH: fetch_done = 1, ir_load = 1.
    - DATA load: data_done = 1, mdr_load = 1.
    - DATA store: data_done = 1 only.
  - Next state is always IDLE.
- Latency: request sampled at edge k → done pulse in cycle k+MEM_WAIT+1. Minimum request-to-request spacing is MEM_WAIT+2 cycles.
- A requester that still holds its request in the IDLE cycle after DONE gets a new access; requesters deassert on seeing done.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- busy = 1 in ACCESS and DONE.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - address-source constants: SRC_PC = 2'b00, SRC_LOADSIZE = 2'b01, SRC_A = 2'b10, SRC_B = 2'b11;
  - state encoding: IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  - kind encoding: FETCH = 0, DATA = 1.
- No sub-module; the wait counter stays inline.
- The address mux itself remains a separate instance driven by mem_sel.

Test Plan:
1. Reset: assert reset for 2 cycles with both requests high → mem_sel = 00, all strobes 0, busy = 0 during and in the first cycle after release.
2. Fetch, MEM_WAIT = 2: fetch_req sampled at edge 0 → mem_sel = 00 and mem_wr = 0 in cycles 1–2; fetch_done = ir_load = 1 in cycle 3 only; IDLE in cycle 4.
3. Store from reg B: data_req = 1, data_src = 11, data_wr = 1 at edge 0 → mem_sel = 11 in cycles 1–3; mem_wr = 1 in cycles 1–2 only; data_done = 1 and mdr_load = 0 in cycle 3.
4. Simultaneous requests: fetch_req = data_req = 1, data_src = 01, load → LoadSize access first (mem_sel = 01, mdr_load in cycle 3); fetch starts at edge 4 and ir_load fires in cycle 7.
5. Reset mid-access: store with data_src = 10; assert reset at edge 2 → mem_wr = 0 and mem_sel = 00 from cycle 3; no data_done ever pulses.
6. Held request, MEM_WAIT = 1: fetch_req held continuously → fetch_done pulses every 3 cycles; data_src toggling during ACCESS does not change mem_sel.
